// File: rtl/conv_tap_sequencer_pkg.sv
// Shared definitions for the convolution tap sequencer: FSM states and B-bus source codes.
package conv_tap_sequencer_pkg;

    localparam int TAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD_K,
        ST_LOAD_P,
        ST_WRITE,
        ST_DONE
    } state_e;

    // K0 is the base of K0..K8 and P1 the base of P1..P3; the rest are fixed sources.
    typedef enum logic [4:0] {
        BSEL_HOLD = 5'b00000,
        BSEL_K0   = 5'b00010,
        BSEL_P1   = 5'b01011,
        BSEL_CV   = 5'b01111,
        BSEL_MBRU = 5'b10001,
        BSEL_PC   = 5'b10011,
        BSEL_MAR  = 5'b10111
    } bsel_e;

endpackage

// File: rtl/conv_tap_sequencer_tap_counter.sv
// Tap index counter: clear, increment, hold on stall; exposes the value the next edge will load.
module tap_counter
    import conv_tap_sequencer_pkg::*;
#(
    parameter int NTAPS = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_stall,
    output logic [TAP_W-1:0] o_tap,
    output logic [TAP_W-1:0] o_tap_nxt,
    output logic             o_last
);

    logic [TAP_W-1:0] r_tap;

    always_comb begin
        o_tap_nxt = r_tap;
        if (!i_stall) begin
            if (i_clr) begin
                o_tap_nxt = '0;
            end else if (i_inc) begin
                o_tap_nxt = r_tap + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tap <= '0;
        end else begin
            r_tap <= o_tap_nxt;
        end
    end

    assign o_tap  = r_tap;
    assign o_last = (r_tap == TAP_W'(NTAPS - 1));

endmodule

// File: rtl/conv_tap_sequencer.sv
// Sequences one NTAPS-tap convolution output: clear AC, load K / MAC P per tap, write CV, pulse done.
module conv_tap_sequencer
    import conv_tap_sequencer_pkg::*;
#(
    parameter int NTAPS = 9,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic [SEL_W-1:0] bus_sel,
    output logic             k_load,
    output logic             mac_en,
    output logic             acc_clr,
    output logic             cv_wr,
    output logic [3:0]       tap,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TAP_W-1:0] w_tap;
    logic [TAP_W-1:0] w_tap_nxt;
    logic             w_tap_last;
    logic             w_tap_clr;
    logic             w_tap_inc;

    logic [SEL_W-1:0] r_bus_sel, w_bus_sel;
    logic             r_k_load, w_k_load;
    logic             r_mac_en, w_mac_en;
    logic             r_acc_clr, w_acc_clr;
    logic             r_cv_wr, w_cv_wr;
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    assign w_tap_clr = (r_state == ST_CLR);
    assign w_tap_inc = (r_state == ST_LOAD_P) && !w_tap_last;

    tap_counter #(
        .NTAPS (NTAPS)
    ) u_tap_counter (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_tap_clr),
        .i_inc     (w_tap_inc),
        .i_stall   (stall),
        .o_tap     (w_tap),
        .o_tap_nxt (w_tap_nxt),
        .o_last    (w_tap_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (!stall) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = start ? ST_CLR : ST_IDLE;
            ST_CLR:    w_state_nxt = ST_LOAD_K;
            ST_LOAD_K: w_state_nxt = ST_LOAD_P;
            ST_LOAD_P: w_state_nxt = w_tap_last ? ST_WRITE : ST_LOAD_K;
            ST_WRITE:  w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and tap so the registered copies line up with r_state.
    always_comb begin
        w_bus_sel = SEL_W'(BSEL_HOLD);
        w_k_load  = 1'b0;
        w_mac_en  = 1'b0;
        w_acc_clr = 1'b0;
        w_cv_wr   = 1'b0;
        w_done    = 1'b0;
        w_busy    = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_CLR: begin
                w_acc_clr = 1'b1;
            end
            ST_LOAD_K: begin
                w_bus_sel = SEL_W'(BSEL_K0) + SEL_W'(w_tap_nxt);
                w_k_load  = 1'b1;
            end
            ST_LOAD_P: begin
                w_bus_sel = SEL_W'(BSEL_P1) + SEL_W'(w_tap_nxt / TAP_W'(3));
                w_mac_en  = 1'b1;
            end
            ST_WRITE: begin
                w_bus_sel = SEL_W'(BSEL_CV);
                w_cv_wr   = 1'b1;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_bus_sel = SEL_W'(BSEL_HOLD);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_sel <= '0;
            r_k_load  <= 1'b0;
            r_mac_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_cv_wr   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (!stall) begin
            r_bus_sel <= w_bus_sel;
            r_k_load  <= w_k_load;
            r_mac_en  <= w_mac_en;
            r_acc_clr <= w_acc_clr;
            r_cv_wr   <= w_cv_wr;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign bus_sel = r_bus_sel;
    assign k_load  = r_k_load;
    assign mac_en  = r_mac_en;
    assign acc_clr = r_acc_clr;
    assign cv_wr   = r_cv_wr;
    assign tap     = w_tap;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Scoreboard bench: a predictor queues each run's expected cycle sequence; a monitor compares per cycle.
module tb_conv_tap_sequencer;

    localparam int NTAPS = 9;
    localparam int SEL_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic [SEL_W-1:0] bus_sel;
    logic             k_load;
    logic             mac_en;
    logic             acc_clr;
    logic             cv_wr;
    logic [3:0]       tap;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    conv_tap_sequencer #(
        .NTAPS (NTAPS),
        .SEL_W (SEL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .bus_sel (bus_sel),
        .k_load  (k_load),
        .mac_en  (mac_en),
        .acc_clr (acc_clr),
        .cv_wr   (cv_wr),
        .tap     (tap),
        .busy    (busy),
        .done    (done)
    );

    // strb = {k_load, mac_en, acc_clr, cv_wr, done}; tap < 0 means not checked
    typedef struct {
        int         sel;
        logic [4:0] strb;
        int         tap;
    } ev_t;

    ev_t        q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t_acc = 0;
    int         n_stall = 0;
    bit         prev_rst = 1'b0;
    bit         was_empty;
    logic [4:0] m_strb;
    ev_t        m_e;

    task automatic chk(input string nm, input bit ok, input string detail);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: %s", nm, cyc, detail);
        end
    endtask

    // One computation, expressed as the list of cycles it should present.
    task automatic push_run();
        ev_t e;
        e.sel = 0; e.strb = 5'b00100; e.tap = -1;
        q.push_back(e);
        for (int t = 0; t < NTAPS; t++) begin
            e.sel = 2 + t;       e.strb = 5'b10000; e.tap = t;
            q.push_back(e);
            e.sel = 11 + t / 3;  e.strb = 5'b01000; e.tap = t;
            q.push_back(e);
        end
        e.sel = 15; e.strb = 5'b00010; e.tap = NTAPS - 1;
        q.push_back(e);
        e.sel = 0;  e.strb = 5'b00001; e.tap = NTAPS - 1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        cyc++;
        was_empty = (q.size() == 0);
        m_strb = {k_load, mac_en, acc_clr, cv_wr, done};
        if (prev_rst) begin
            chk("reset_state", busy == 1'b0 && tap == 4'd0 && bus_sel == '0 && m_strb == 5'b0,
                $sformatf("got busy=%b tap=%0d sel=%0h strb=%b, want busy=0 tap=0 sel=0 strb=00000",
                          busy, tap, bus_sel, m_strb));
        end else if (busy) begin
            if (was_empty) begin
                chk("unexpected_busy", 1'b0,
                    $sformatf("got busy=1 sel=%0h strb=%b, want idle", bus_sel, m_strb));
            end else begin
                m_e = q[0];
                chk("sequence",
                    bus_sel == m_e.sel && m_strb == m_e.strb && (m_e.tap < 0 || tap == m_e.tap),
                    $sformatf("got sel=%0h strb=%b tap=%0d, want sel=%0h strb=%b tap=%0d",
                              bus_sel, m_strb, tap, m_e.sel, m_e.strb, m_e.tap));
                if (!stall) begin
                    if (m_e.strb[0]) begin
                        chk("latency", (cyc - t_acc) == 2 * NTAPS + 3 + n_stall,
                            $sformatf("got %0d cycles, want %0d", cyc - t_acc, 2 * NTAPS + 3 + n_stall));
                    end
                    void'(q.pop_front());
                end else begin
                    n_stall++;
                end
            end
        end else begin
            chk("idle", bus_sel == '0 && m_strb == 5'b0 && was_empty,
                $sformatf("got sel=%0h strb=%b pending=%0d, want sel=0 strb=00000 pending=0",
                          bus_sel, m_strb, q.size()));
        end
        if (rst) begin
            q.delete();
        end else if (start && !stall && was_empty) begin
            push_run();
            t_acc = cyc;
            n_stall = 0;
        end
        prev_rst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (done) return;
            step();
        end
        chk("timeout_done", 1'b0, "got no done within 200 cycles, want done");
    endtask

    task automatic wait_tap(input bit want_mac, input int want_tap);
        for (int i = 0; i < 200; i++) begin
            if (busy && (want_mac ? mac_en : k_load) && tap == want_tap) return;
            step();
        end
        chk("timeout_tap", 1'b0, $sformatf("got no tap=%0d within 200 cycles, want it", want_tap));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // plain run
        pulse_start();
        wait_done();
        step(); step();

        // stall 3 cycles in LOAD_P at tap 4
        pulse_start();
        wait_tap(1'b1, 4);
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        wait_done();
        step(); step();

        // start re-pulsed mid-run is ignored
        pulse_start();
        wait_tap(1'b0, 2);
        pulse_start();
        wait_done();
        step(); step();

        // reset at tap 6 aborts, then a fresh run
        pulse_start();
        wait_tap(1'b0, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        pulse_start();
        wait_done();
        step(); step();

        // start together with stall in IDLE is ignored
        start = 1'b1;
        stall = 1'b1;
        step();
        start = 1'b0;
        stall = 1'b0;
        repeat (3) step();

        // back-to-back: start during DONE ignored, start in the following cycle accepted
        pulse_start();
        wait_done();
        start = 1'b1;
        step();
        pulse_start();
        wait_done();
        step(); step();

        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy && q.size() == 0) break;
            step();
        end
        step(); step();
        chk("drain", q.size() == 0 && !busy,
            $sformatf("got pending=%0d busy=%b, want pending=0 busy=0", q.size(), busy));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
